// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag index and sequencer state definitions
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_INC   = 4'd5,
    OP_MOVA  = 4'd6,
    OP_MOVB  = 4'd7,
    OP_LOADI = 4'd8,
    OP_STORE = 4'd9
  } alu_op_e;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_OUT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x BW register file, two async read ports, one sync write port
module alu_regfile
  import alu_pkg::*;
#(
  parameter int BW    = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [BW-1:0]            i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [BW-1:0]            o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [BW-1:0]            o_rdata_b
);

  logic [BW-1:0] r_regs [NREGS];

  // storage: cleared asynchronously, written on the write-back cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle ALU sequencer; ALU_SEQ_CTRL_PERF_EN adds perf counters
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int BW    = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [3:0]               instr_op,
  input  logic [$clog2(NREGS)-1:0] instr_rd,
  input  logic [$clog2(NREGS)-1:0] instr_ra,
  input  logic [$clog2(NREGS)-1:0] instr_rb,
  input  logic [BW-1:0]            instr_imm,
  output logic [BW-1:0]            alu_in_a,
  output logic [BW-1:0]            alu_in_b,
  output logic [3:0]               alu_opcode,
  input  logic [BW-1:0]            alu_out,
  input  logic [2:0]               alu_flags,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [BW-1:0]            res_data,
  output logic [2:0]               flags,
`ifdef ALU_SEQ_CTRL_PERF_EN
  output logic [31:0]              perf_instr,
  output logic [31:0]              perf_ovf,
`endif
  output logic                     err
);

  localparam int AW = $clog2(NREGS);

  seq_state_e    r_state, w_next_state;
  logic          w_accept, w_we;
  logic          w_is_alu, w_is_loadi, w_is_store, w_is_illegal;
  logic [AW-1:0] r_rd;
  logic          r_is_alu;
  logic [BW-1:0] r_wdata;
  logic [2:0]    r_cflags;
  logic [BW-1:0] w_rdata_a, w_rdata_b;

  assign w_is_alu     = ~instr_op[3];
  assign w_is_loadi   = (instr_op == OP_LOADI);
  assign w_is_store   = (instr_op == OP_STORE);
  assign w_is_illegal = instr_op[3] & ~w_is_loadi & ~w_is_store;

  // read ports are only consumed in IDLE, so they follow the offered instruction directly
  alu_regfile #(.BW(BW), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (r_rd),
    .i_wdata   (r_wdata),
    .i_raddr_a (instr_ra),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (instr_rb),
    .o_rdata_b (w_rdata_b)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // next-state, handshake and write-enable decode
  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    w_accept     = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        w_accept    = instr_valid;
        if (instr_valid) begin
          if (w_is_alu)        w_next_state = S_EXEC;
          else if (w_is_loadi) w_next_state = S_WB;
          else if (w_is_store) w_next_state = S_OUT;
        end
      end
      S_EXEC: w_next_state = S_WB;
      S_WB: begin
        w_we         = 1'b1;
        w_next_state = S_IDLE;
      end
      S_OUT: if (res_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // datapath: operand launch, result capture, flag write-back and store stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd       <= '0;
      r_is_alu   <= 1'b0;
      r_wdata    <= '0;
      r_cflags   <= '0;
      alu_in_a   <= '0;
      alu_in_b   <= '0;
      alu_opcode <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      flags      <= '0;
      err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd     <= instr_rd;
        r_is_alu <= w_is_alu;
        // immediate parks here for LOADI; ALU ops overwrite it in EXEC
        r_wdata  <= instr_imm;
        if (w_is_alu) begin
          alu_in_a   <= w_rdata_a;
          alu_in_b   <= w_rdata_b;
          alu_opcode <= instr_op;
        end
        if (w_is_store) begin
          res_data  <= w_rdata_a;
          res_valid <= 1'b1;
        end
        if (w_is_illegal) err <= 1'b1;
      end
      if (r_state == S_EXEC) begin
        r_wdata  <= alu_out;
        r_cflags <= alu_flags;
      end
      if (w_we && r_is_alu) flags <= r_cflags;
      if (r_state == S_OUT && res_ready) res_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_CTRL_PERF_EN
  // saturating counters for accepted instructions and overflow write-backs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr <= '0;
      perf_ovf   <= '0;
    end else begin
      if (w_accept && perf_instr != '1) perf_instr <= perf_instr + 32'd1;
      if (w_we && r_is_alu && r_cflags[FLAG_OVF] && perf_ovf != '1)
        perf_ovf <= perf_ovf + 32'd1;
    end
  end
`endif

endmodule
